// File: rtl/tcdm_filter_cfg_slave.sv
// Configuration slave for the TCDM address filter.
// It answers TCDM requests with zero wait states and holds the rule
// registers, the filter enable/lock bits and a small violation log that
// is fed by the filter's error pulse.
module tcdm_filter_cfg_slave #(
    parameter int N_RULES    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    input  logic [ADDR_WIDTH-1:0]   add_i,
    input  logic                    wen_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [BE_WIDTH-1:0]     be_i,
    output logic                    gnt_o,
    output logic [DATA_WIDTH-1:0]   r_rdata_o,
    output logic                    r_valid_o,
    input  logic                    err_i,
    input  logic [ADDR_WIDTH-1:0]   err_add_i,
    output logic [N_RULES*32-1:0]   rules_o,
    output logic                    filter_en_o,
    output logic                    irq_o
);

    localparam logic [31:0] BadData = 32'hBADE5505;

    // Register state
    logic                  filterEn_q, filterEn_d;
    logic                  lock_q,     lock_d;
    logic                  irqEn_q,    irqEn_d;
    logic                  pending_q,  pending_d;
    logic                  overflow_q, overflow_d;
    logic [ADDR_WIDTH-1:0] errAddr_q,  errAddr_d;
    logic [15:0]           errCnt_q,   errCnt_d;
    logic [31:0]           rules_q [N_RULES];
    logic [31:0]           rules_d [N_RULES];
    logic                  rValid_q,   rValid_d;
    logic [31:0]           rData_q,    rData_d;
    logic                  irq_q;

    // Decode helpers
    logic [5:0]  regIdx;
    logic        wrEn;
    logic        rdEn;
    logic        stsClr;
    logic        cntClr;
    logic        pendingBase;
    logic        overflowBase;
    logic [15:0] cntBase;
    logic [31:0] readMux;
    logic        unusedAddrBits;

    assign regIdx = add_i[7:2];
    assign wrEn   = req_i & ~wen_i;
    assign rdEn   = req_i & wen_i;
    assign gnt_o  = req_i & ~rst;

    assign unusedAddrBits = ^{add_i[ADDR_WIDTH-1:8], add_i[1:0]};

    // Read multiplexer: value seen by a read issued in the current cycle
    always_comb begin
        readMux = BadData;
        case (regIdx)
            6'd0:    readMux = {29'd0, irqEn_q, lock_q, filterEn_q};
            6'd1:    readMux = {30'd0, overflow_q, pending_q};
            6'd2:    readMux = 32'(errAddr_q);
            6'd3:    readMux = {16'd0, errCnt_q};
            default: begin
                for (int i = 0; i < N_RULES; i++) begin
                    if (regIdx == 6'(i + 4)) begin
                        readMux = rules_q[i];
                    end
                end
            end
        endcase
    end

    // Next-state for control, rules and the violation log (clear before error)
    always_comb begin
        filterEn_d = filterEn_q;
        lock_d     = lock_q;
        irqEn_d    = irqEn_q;
        errAddr_d  = errAddr_q;
        for (int i = 0; i < N_RULES; i++) begin
            rules_d[i] = rules_q[i];
        end

        if (wrEn && !lock_q && regIdx == 6'd0 && be_i[0]) begin
            filterEn_d = wdata_i[0];
            irqEn_d    = wdata_i[2];
            lock_d     = lock_q | wdata_i[1];
        end

        for (int i = 0; i < N_RULES; i++) begin
            if (wrEn && !lock_q && regIdx == 6'(i + 4)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        rules_d[i][8*b +: 8] = wdata_i[8*b +: 8];
                    end
                end
            end
        end

        stsClr       = wrEn && regIdx == 6'd1 && be_i[0] && wdata_i[0];
        cntClr       = wrEn && regIdx == 6'd3 && (|be_i);
        pendingBase  = stsClr ? 1'b0 : pending_q;
        overflowBase = stsClr ? 1'b0 : overflow_q;
        cntBase      = cntClr ? 16'd0 : errCnt_q;

        pending_d  = pendingBase;
        overflow_d = overflowBase;
        errCnt_d   = cntBase;
        if (err_i) begin
            if (!pendingBase) begin
                errAddr_d = err_add_i;
                pending_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
            if (cntBase != 16'hFFFF) begin
                errCnt_d = cntBase + 16'd1;
            end
        end

        rValid_d = req_i;
        rData_d  = rdEn ? readMux : 32'd0;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filterEn_q <= 1'b0;
            lock_q     <= 1'b0;
            irqEn_q    <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            errAddr_q  <= '0;
            errCnt_q   <= 16'd0;
            for (int i = 0; i < N_RULES; i++) begin
                rules_q[i] <= 32'd0;
            end
            rValid_q   <= 1'b0;
            rData_q    <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            filterEn_q <= filterEn_d;
            lock_q     <= lock_d;
            irqEn_q    <= irqEn_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            errAddr_q  <= errAddr_d;
            errCnt_q   <= errCnt_d;
            for (int i = 0; i < N_RULES; i++) begin
                rules_q[i] <= rules_d[i];
            end
            rValid_q   <= rValid_d;
            rData_q    <= rData_d;
            irq_q      <= pending_q & irqEn_q;
        end
    end

    // Flatten the rule array onto the filter-facing vector
    always_comb begin
        for (int i = 0; i < N_RULES; i++) begin
            rules_o[32*i +: 32] = rules_q[i];
        end
    end

    assign r_valid_o   = rValid_q;
    assign r_rdata_o   = DATA_WIDTH'(rData_q);
    assign filter_en_o = filterEn_q;
    assign irq_o       = irq_q;

endmodule
